// File: rtl/reg_writeback_pkg.sv
// Shared constants, entry layout and helpers for the register write-back arbiter.
package reg_writeback_pkg;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         FIFO_DEPTH   = 2;
    localparam logic [2:0] STARVE_LIMIT = 3'd7;

    // One buffered multi-cycle result: destination register on top, 37 bits total.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    function automatic logic reg_hit(input logic [31:1] pending, input logic [4:0] rd);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (rd == 5'(i)) hit = pending[i];
        end
        return hit;
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Pipeline, multi-cycle-unit, decode and register-file signals of the write-back block.
interface reg_writeback_if;

    logic        WB_RegWrite;
    logic [4:0]  WB_Write_register;
    logic [31:0] WB_Write_data;

    logic        MDU_issue;
    logic [4:0]  MDU_issue_register;
    logic        MDU_valid;
    logic [4:0]  MDU_register;
    logic [31:0] MDU_data;
    logic        MDU_ready;

    logic [4:0]  Read_register1;
    logic [4:0]  Read_register2;
    logic [4:0]  Dest_register;
    logic        Stall;

    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;

    modport master (
        output WB_RegWrite, WB_Write_register, WB_Write_data,
        output MDU_issue, MDU_issue_register, MDU_valid, MDU_register, MDU_data,
        output Read_register1, Read_register2, Dest_register,
        input  MDU_ready, Stall, RegWrite, Write_register, Write_data
    );

    modport slave (
        input  WB_RegWrite, WB_Write_register, WB_Write_data,
        input  MDU_issue, MDU_issue_register, MDU_valid, MDU_register, MDU_data,
        input  Read_register1, Read_register2, Dest_register,
        output MDU_ready, Stall, RegWrite, Write_register, Write_data
    );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Small result buffer for multi-cycle results awaiting a free register-file write slot.
module wb_fifo
    import reg_writeback_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_data,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    // Pointers wrap naturally because the depth is a power of two.
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    wb_entry_t        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; r_count alone decides which slots hold valid data.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port arbiter: pipeline writes first, buffered multi-cycle results
// otherwise, with a pending scoreboard and starvation counter feeding the decode stall.
module reg_writeback
    import reg_writeback_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    reg_writeback_if.slave bus
);

    logic [31:1] r_pending;
    logic [2:0]  r_starve;

    logic [31:1] w_pending_next;
    logic        w_wb_active;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    wb_entry_t   w_head;
    wb_entry_t   w_push_entry;

    assign w_wb_active  = bus.WB_RegWrite && (bus.WB_Write_register != REG_ZERO);
    // Results for r0 are acknowledged but never stored.
    assign w_push       = bus.MDU_valid && !w_fifo_full && (bus.MDU_register != REG_ZERO);
    assign w_pop        = !w_fifo_empty && !w_wb_active;
    assign w_push_entry = '{rd: bus.MDU_register, data: bus.MDU_data};

    wb_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign bus.MDU_ready = !w_fifo_full;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bus.RegWrite       = 1'b0;
        bus.Write_register = REG_ZERO;
        bus.Write_data     = '0;
        if (!reset) begin
            if (w_wb_active) begin
                bus.RegWrite       = 1'b1;
                bus.Write_register = bus.WB_Write_register;
                bus.Write_data     = bus.WB_Write_data;
            end else if (!w_fifo_empty) begin
                bus.RegWrite       = 1'b1;
                bus.Write_register = w_head.rd;
                bus.Write_data     = w_head.data;
            end
        end
    end

    // Set is applied after clear so a re-issue to the register being retired stays pending.
    always_comb begin
        w_pending_next = r_pending;
        for (int i = 1; i < 32; i++) begin
            if (w_pop && (w_head.rd == 5'(i)))                        w_pending_next[i] = 1'b0;
            if (bus.MDU_issue && (bus.MDU_issue_register == 5'(i)))   w_pending_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_starve  <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_fifo_empty || w_pop)
                r_starve <= '0;
            else if (r_starve != STARVE_LIMIT)
                r_starve <= r_starve + 3'd1;
        end
    end

    assign bus.Stall = reg_hit(r_pending, bus.Read_register1)
                     | reg_hit(r_pending, bus.Read_register2)
                     | reg_hit(r_pending, bus.Dest_register)
                     | (r_starve == STARVE_LIMIT);

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: vector table plus scoreboard-driven sequences.
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_writeback_if bus();

    reg_writeback dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    ent_t        sb[$];
    logic [31:0] m_pend;
    int          m_starve;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.WB_RegWrite        = 1'b0;
        bus.WB_Write_register  = 5'd0;
        bus.WB_Write_data      = 32'd0;
        bus.MDU_issue          = 1'b0;
        bus.MDU_issue_register = 5'd0;
        bus.MDU_valid          = 1'b0;
        bus.MDU_register       = 5'd0;
        bus.MDU_data           = 32'd0;
        bus.Read_register1     = 5'd0;
        bus.Read_register2     = 5'd0;
        bus.Dest_register      = 5'd0;
    endtask

    function automatic logic m_hit(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r];
    endfunction

    // Check outputs against the model, clock once, then advance the model.
    task automatic cycle();
        logic        wb_act, pop, push, ready_exp, nonempty;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        ent_t        head;
        #1;
        wb_act    = bus.WB_RegWrite && (bus.WB_Write_register != 5'd0);
        nonempty  = (sb.size() > 0);
        ready_exp = (sb.size() < FIFO_DEPTH);
        pop       = !wb_act && nonempty;
        exp_we = 1'b0; exp_rd = 5'd0; exp_data = 32'd0;
        if (wb_act) begin
            exp_we = 1'b1; exp_rd = bus.WB_Write_register; exp_data = bus.WB_Write_data;
        end else if (pop) begin
            head = sb.pop_front();
            exp_we = 1'b1; exp_rd = head.rd; exp_data = head.data;
        end
        check("RegWrite",       bus.RegWrite,       exp_we);
        check("Write_register", bus.Write_register, exp_rd);
        check("Write_data",     bus.Write_data,     exp_data);
        check("MDU_ready",      bus.MDU_ready,      ready_exp);
        check("Stall", bus.Stall, m_hit(bus.Read_register1) | m_hit(bus.Read_register2)
                                | m_hit(bus.Dest_register) | (m_starve == 7));
        push = bus.MDU_valid && ready_exp && (bus.MDU_register != 5'd0);
        @(posedge clk);
        if (pop) m_pend[head.rd] = 1'b0;
        if (bus.MDU_issue && bus.MDU_issue_register != 5'd0) m_pend[bus.MDU_issue_register] = 1'b1;
        if (!nonempty || pop) m_starve = 0;
        else if (m_starve < 7) m_starve++;
        if (push) sb.push_back('{bus.MDU_register, bus.MDU_data});
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        check("reset MDU_ready", bus.MDU_ready, 1'b1);
        check("reset RegWrite",  bus.RegWrite,  1'b0);
        check("reset Stall",     bus.Stall,     1'b0);
        sb.delete();
        m_pend   = 32'd0;
        m_starve = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b1, 5'd3,  32'h0000_AAAA, 1'b1, 5'd3,  32'h0000_AAAA};
        vt[1] = '{1'b1, 5'd0,  32'h0000_5555, 1'b0, 5'd0,  32'h0000_0000};
        vt[2] = '{1'b0, 5'd7,  32'h0000_0001, 1'b0, 5'd0,  32'h0000_0000};
        vt[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
        vt[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  32'h0000_0000};
        vt[5] = '{1'b0, 5'd0,  32'h0000_DEAD, 1'b0, 5'd0,  32'h0000_0000};

        do_reset();

        // Pipeline-only write-port vectors.
        foreach (vt[i]) begin
            bus.WB_RegWrite       = vt[i].we;
            bus.WB_Write_register = vt[i].rd;
            bus.WB_Write_data     = vt[i].data;
            #1;
            check($sformatf("vec%0d RegWrite", i),       bus.RegWrite,       vt[i].exp_we);
            check($sformatf("vec%0d Write_register", i), bus.Write_register, vt[i].exp_rd);
            check($sformatf("vec%0d Write_data", i),     bus.Write_data,     vt[i].exp_data);
            cycle();
        end
        idle_inputs();

        // Issue r8, result 5 cycles later, decode reads r8 throughout.
        bus.MDU_issue = 1'b1; bus.MDU_issue_register = 5'd8; bus.Read_register1 = 5'd8;
        cycle();
        bus.MDU_issue = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("r8 stall while pending", bus.Stall, 1'b1);
            cycle();
        end
        bus.MDU_valid = 1'b1; bus.MDU_register = 5'd8; bus.MDU_data = 32'h1234;
        #1 check("r8 no bypass", bus.RegWrite, 1'b0);
        cycle();
        bus.MDU_valid = 1'b0;
        #1;
        check("r8 RegWrite",       bus.RegWrite,       1'b1);
        check("r8 Write_register", bus.Write_register, 5'd8);
        check("r8 Write_data",     bus.Write_data,     32'h1234);
        cycle();
        #1 check("r8 pending cleared", bus.Stall, 1'b0);
        cycle();
        idle_inputs();

        // Result for r0 is swallowed.
        bus.MDU_valid = 1'b1; bus.MDU_register = 5'd0; bus.MDU_data = 32'h77;
        #1 check("r0 ready", bus.MDU_ready, 1'b1);
        cycle();
        bus.MDU_valid = 1'b0;
        #1;
        check("r0 no write", bus.RegWrite,  1'b0);
        check("r0 ready after", bus.MDU_ready, 1'b1);
        cycle();

        // Pipeline hogs the port while two results are buffered.
        bus.WB_RegWrite = 1'b1; bus.WB_Write_register = 5'd3;
        for (int i = 0; i < 12; i++) begin
            bus.WB_Write_data = 32'h300 + i;
            bus.MDU_valid     = 1'b1;
            bus.MDU_register  = (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12;
            bus.MDU_data      = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
            cycle();
        end
        #1;
        check("starve MDU_ready", bus.MDU_ready,      1'b0);
        check("starve Stall",     bus.Stall,          1'b1);
        check("starve WB wins",   bus.Write_register, 5'd3);
        bus.WB_RegWrite = 1'b0;
        #1 check("drain head r10", bus.Write_register, 5'd10);
        cycle();
        #1 check("drain r11", bus.Write_register, 5'd11);
        cycle();
        bus.MDU_valid = 1'b0;
        #1 check("drain r12", bus.Write_data, 32'hC);
        cycle();
        idle_inputs();
        cycle();

        // Re-issue of r5 in the cycle its head is popped keeps it pending.
        bus.MDU_issue = 1'b1; bus.MDU_issue_register = 5'd5; bus.Read_register2 = 5'd5;
        cycle();
        bus.MDU_issue = 1'b0;
        bus.MDU_valid = 1'b1; bus.MDU_register = 5'd5; bus.MDU_data = 32'h55;
        cycle();
        bus.MDU_valid = 1'b0;
        bus.MDU_issue = 1'b1;
        #1 check("r5 head popping", bus.Write_register, 5'd5);
        cycle();
        bus.MDU_issue = 1'b0;
        #1 check("r5 set wins", bus.Stall, 1'b1);
        cycle();
        bus.MDU_valid = 1'b1; bus.MDU_data = 32'h56;
        cycle();
        bus.MDU_valid = 1'b0;
        cycle();
        #1 check("r5 cleared", bus.Stall, 1'b0);
        cycle();
        idle_inputs();

        // WAW hazard on the decode destination.
        bus.MDU_issue = 1'b1; bus.MDU_issue_register = 5'd6;
        bus.Read_register1 = 5'd1; bus.Read_register2 = 5'd2; bus.Dest_register = 5'd6;
        cycle();
        bus.MDU_issue = 1'b0;
        #1 check("r6 WAW stall", bus.Stall, 1'b1);
        cycle();
        bus.MDU_valid = 1'b1; bus.MDU_register = 5'd6; bus.MDU_data = 32'h66;
        cycle();
        bus.MDU_valid = 1'b0;
        cycle();
        #1 check("r6 cleared", bus.Stall, 1'b0);
        cycle();
        idle_inputs();

        // Asynchronous reset with a full buffer and r9 pending.
        bus.MDU_issue = 1'b1; bus.MDU_issue_register = 5'd9; bus.Read_register1 = 5'd9;
        bus.WB_RegWrite = 1'b1; bus.WB_Write_register = 5'd3; bus.WB_Write_data = 32'h3;
        bus.MDU_valid = 1'b1; bus.MDU_register = 5'd20; bus.MDU_data = 32'h20;
        cycle();
        bus.MDU_issue = 1'b0;
        bus.MDU_register = 5'd21; bus.MDU_data = 32'h21;
        cycle();
        bus.MDU_valid = 1'b0;
        #1;
        check("pre-reset full",   bus.MDU_ready, 1'b0);
        check("pre-reset r9 hit", bus.Stall,     1'b1);
        bus.WB_RegWrite = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("async reset MDU_ready", bus.MDU_ready, 1'b1);
        check("async reset RegWrite",  bus.RegWrite,  1'b0);
        check("async reset Stall",     bus.Stall,     1'b0);
        sb.delete();
        m_pend   = 32'd0;
        m_starve = 0;
        @(negedge clk);
        reset = 1'b0;
        #1 check("post-reset r9 clear", bus.Stall, 1'b0);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high, named clk and reset.
REQ-002 Port clk  input  1  rising-edge clock shared with the register file.
REQ-003 Port reset  input  1  asynchronous active-high reset.
REQ-004 Port WB_RegWrite  input  1  pipeline write-back stage requests a write.
REQ-005 Port WB_Write_register  input  5  pipeline destination register.
REQ-006 Port WB_Write_data  input  32  pipeline result.
REQ-007 Port MDU_issue  input  1  multi-cycle unit has accepted an op this cycle.
REQ-008 Port MDU_issue_register  input  5  destination register of the issued op.
REQ-009 Port MDU_valid  input  1  multi-cycle result offered.
REQ-010 Port MDU_register  input  5  result destination register.
REQ-011 Port MDU_data  input  32  result value.
REQ-012 Port MDU_ready  output  1  result buffer can accept.
REQ-013 Port Read_register1, Read_register2, Dest_register  input  5 each  decode-stage source and destination registers.
REQ-014 Port Stall  output  1  decode must hold.
REQ-015 Port RegWrite, Write_register, Write_data  output  1/5/32  drive the register-file write port.

Function
REQ-016 The 2-entry FIFO SHALL buffer MDU results; MDU_ready = not full, and the push occurs on MDU_valid and MDU_ready at a rising edge.
REQ-017 A push with MDU_register = 0 SHALL be accepted and discarded: no entry is created and no scoreboard change occurs.
REQ-018 The write port SHALL be combinational, with this priority:
- pipeline write when WB_RegWrite = 1 and WB_Write_register != 0;
- otherwise the FIFO head, if the FIFO is non-empty (pop at that edge);
- otherwise RegWrite = 0, Write_register = 0, Write_data = 0.
REQ-019 Minimum latency from MDU accept to register-file write SHALL be 1 cycle; there is no same-cycle bypass of the FIFO.
REQ-020 A simultaneous push and pop SHALL be legal when the FIFO is full, but MDU_ready reflects registered fullness, so no push happens while full.
REQ-021 The scoreboard pending[31:1] SHALL behave as follows:
- set at the edge of MDU_issue with MDU_issue_register != 0;
- cleared when the FIFO head for that register is popped;
- if a set and a clear hit the same register in the same cycle, set wins.
REQ-022 The starvation counter (3 bits) SHALL behave as follows:
- increments each cycle the FIFO is non-empty and not popped;
- clears on pop or when the FIFO is empty;
- saturates at 7.
REQ-023 Stall SHALL be combinational OR of:
- pending[Read_register1] (r1 != 0);
- pending[Read_register2] (r2 != 0);
- pending[Dest_register] (WAW);
- starvation counter = 7.
REQ-024 Register 0 SHALL never be written or marked pending.

Reset
REQ-025 While reset is asserted the block SHALL hold FIFO empty, pending all zero, counter 0, MDU_ready = 1, RegWrite = 0, Stall = 0 (with zero read/dest regs).
REQ-026 A reset asserted mid-operation SHALL drop buffered results and pending bits immediately, without a clock edge.

Structure
REQ-027 The shared package SHALL hold REG_ZERO = 5'd0, FIFO_DEPTH = 2, and STARVE_LIMIT = 3'd7.
REQ-028 The FIFO SHALL be the sub-module wb_fifo (37-bit entries, push/pop/full/empty); the scoreboard, arbiter and counter reside in reg_writeback.

Verification
REQ-029 Reset, then MDU_issue to r8, then 5 cycles later MDU_valid r8 = 0x1234 with no WB traffic: Stall = 1 for a decode read of r8 until the write cycle; RegWrite = 1, Write_register = 8, Write_data = 0x1234 one cycle after accept; pending[8] = 0 afterwards.
REQ-030 WB writes r3 every cycle while 2 MDU results are buffered: the MDU results never appear on the write port, MDU_ready = 0, the counter reaches 7 and Stall = 1; first WB idle cycle drains the head.
REQ-031 MDU_valid with register 0: MDU_ready stays 1, the FIFO stays empty, RegWrite stays 0.
REQ-032 MDU_issue r5 in the same cycle as the r5 head pop: pending[5] remains 1 afterwards.
REQ-033 Reset asserted asynchronously with FIFO full and pending[9] = 1: immediately MDU_ready = 1, pending = 0, RegWrite = 0.
REQ-034 Dest_register = r6 pending, with no source hits: Stall = 1 (WAW).
